// File: rtl/clk_freq_meter.sv
// Gated-window frequency meter: counts clk_test rising edges over GATE_CYCLES
// sys_clk cycles and publishes the count, range/no-clock flags and a window count.
module clk_freq_meter #(
  parameter int unsigned      GATE_CYCLES = 200_000_000,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] EXP_MIN     = '0,
  parameter logic [CNT_W-1:0] EXP_MAX     = {CNT_W{1'b1}}
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_test,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             in_range,
  output logic             no_clk,
  output logic [15:0]      win_cnt
);

  localparam int unsigned   GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_sum;
  logic [CNT_W:0]   diff_lo, diff_hi;
  logic             lo_ok, hi_ok;

  assign edge_det = s2 & ~s3;

  always_comb begin
    edge_sum = edge_cnt;
    if (edge_det && !(&edge_cnt)) edge_sum = edge_cnt + CNT_W'(1);
  end

  // Bounds checked via borrow bits so a zero or all-ones bound needs no special case
  always_comb begin
    diff_lo = {1'b0, edge_sum} - {1'b0, EXP_MIN};
    diff_hi = {1'b0, EXP_MAX} - {1'b0, edge_sum};
    lo_ok   = ~diff_lo[CNT_W];
    hi_ok   = ~diff_hi[CNT_W];
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
      in_range   <= 1'b0;
      no_clk     <= 1'b0;
      win_cnt    <= '0;
    end else begin
      s1         <= clk_test;
      s2         <= s1;
      s3         <= s2;
      freq_valid <= 1'b0;
      if (state == IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        if (en) state <= RUN;
      end else if (!en) begin
        state    <= IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (gate_cnt == GATE_LAST) begin
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        freq_cnt   <= edge_sum;
        freq_valid <= 1'b1;
        in_range   <= lo_ok & hi_ok;
        no_clk     <= (edge_sum == '0);
        win_cnt    <= win_cnt + 16'd1;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_sum;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (wide counter with a 24..26 range, and a
// 4-bit saturating counter) checked against a window-arithmetic reference model.
module tb_clk_freq_meter;

  localparam int unsigned G = 100;

  logic sys_clk  = 1'b0;
  logic rst_n    = 1'b0;
  logic en       = 1'b0;
  logic clk_test = 1'b0;

  logic [31:0] fc_a;
  logic        fv_a, ir_a, nc_a;
  logic [15:0] wc_a;
  logic [3:0]  fc_b;
  logic        fv_b, ir_b, nc_b;
  logic [15:0] wc_b;

  int checks = 0;
  int errors = 0;

  int per = 4, hi = 2, ph = 0;
  bit hold_low = 1'b0;

  int          cyc = 0, last_rst = -1, run_start = -1;
  bit          xq[$];
  bit          eq[$];
  bit          m_valid = 1'b0, m_inr_a = 1'b0, m_inr_b = 1'b0, m_noclk = 1'b0;
  logic [31:0] m_freq = '0;
  logic [15:0] m_win = '0;
  logic [73:0] expv = '0;
  logic [73:0] obs;

  assign obs = {fv_a, fc_a, ir_a, nc_a, wc_a, fv_b, fc_b, ir_b, nc_b, wc_b};

  always #5 sys_clk = ~sys_clk;

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .EXP_MIN(32'd24), .EXP_MAX(32'd26)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .clk_test(clk_test),
    .freq_cnt(fc_a), .freq_valid(fv_a), .in_range(ir_a), .no_clk(nc_a), .win_cnt(wc_a)
  );

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .clk_test(clk_test),
    .freq_cnt(fc_b), .freq_valid(fv_b), .in_range(ir_b), .no_clk(nc_b), .win_cnt(wc_b)
  );

  // clk_test level seen at edge j; anything at or before the last reset reads as 0
  function automatic bit xv(int j);
    if (j < 0 || j <= last_rst) return 1'b0;
    return xq[j];
  endfunction

  task automatic model_step();
    int         sum;
    logic [3:0] f4;
    xq.push_back(clk_test);
    m_valid = 1'b0;
    if (!rst_n) begin
      last_rst  = cyc;
      run_start = -1;
      eq.push_back(1'b0);
      m_freq  = '0;
      m_win   = '0;
      m_inr_a = 1'b0;
      m_inr_b = 1'b0;
      m_noclk = 1'b0;
    end else begin
      eq.push_back(xv(cyc - 2) && !xv(cyc - 3));
      if (!en) run_start = -1;
      else if (run_start < 0) run_start = cyc;
      else if ((cyc - run_start) % int'(G) == 0) begin
        sum = 0;
        for (int k = cyc - int'(G) + 1; k <= cyc; k++) sum += int'(eq[k]);
        m_freq  = 32'(sum);
        m_valid = 1'b1;
        m_win   = m_win + 16'd1;
        m_inr_a = (sum >= 24) && (sum <= 26);
        m_inr_b = 1'b1;
        m_noclk = (sum == 0);
      end
    end
    f4   = (m_freq > 32'd15) ? 4'd15 : m_freq[3:0];
    expv = {m_valid, m_freq, m_inr_a, m_noclk, m_win, m_valid, f4, m_inr_b, m_noclk, m_win};
    cyc++;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (hold_low) clk_test = 1'b0;
    else begin
      clk_test = (ph < hi);
      ph = (ph + 1) % per;
    end
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input int budget, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < budget) begin
      tick();
      lat++;
      got = (fv_a === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; per = 4; hi = 2; ph = 0; hold_low = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_zero got=%h exp=0", obs); end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_first_window();
    int lat;
    bit got;
    rst_n = 1'b1;
    wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || lat != int'(G) + 1) begin
      errors++; $display("FAIL first_latency got=%0d exp=%0d", lat, G + 1);
    end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL first_window got=%h exp=%h", obs, expv); end
    wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || lat != int'(G)) begin errors++; $display("FAIL window_period got=%0d exp=%0d", lat, G); end
    checks++;
    if (fc_a !== 32'd25 || nc_a !== 1'b0 || fc_b !== 4'd15) begin
      errors++; $display("FAIL second_window got=%0d/%0d/%0d exp=25/0/15", fc_a, nc_a, fc_b);
    end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL second_model got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_no_clk();
    int          lat;
    bit          got;
    logic [15:0] w_exp;
    hold_low = 1'b1;
    repeat (2) wait_valid(int'(G) + 20, lat, got);
    w_exp = m_win + 16'd1;
    wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || fc_a !== 32'd0 || nc_a !== 1'b1 || ir_a !== 1'b0 || ir_b !== 1'b1 || fc_b !== 4'd0) begin
      errors++;
      $display("FAIL no_clk got cnt=%0d no_clk=%0d ir_a=%0d ir_b=%0d exp 0/1/0/1", fc_a, nc_a, ir_a, ir_b);
    end
    checks++;
    if (wc_a !== w_exp || wc_b !== w_exp) begin
      errors++; $display("FAIL no_clk_win got=%0d/%0d exp=%0d", wc_a, wc_b, w_exp);
    end
    hold_low = 1'b0; ph = 0;
  endtask

  task automatic test_range();
    int lat;
    bit got;
    per = 4; hi = 2; ph = 0;
    repeat (2) wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || fc_a !== 32'd25 || ir_a !== 1'b1) begin
      errors++; $display("FAIL range_in got cnt=%0d ir=%0d exp 25/1", fc_a, ir_a);
    end
    per = 5; hi = 3; ph = 0;
    repeat (2) wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || fc_a !== 32'd20 || ir_a !== 1'b0 || nc_a !== 1'b0) begin
      errors++; $display("FAIL range_out got cnt=%0d ir=%0d exp 20/0", fc_a, ir_a);
    end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL range_model got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_abort();
    int          lat;
    bit          got;
    logic [31:0] held;
    per = 4; hi = 2; ph = 0;
    wait_valid(int'(G) + 20, lat, got);
    held = m_freq;
    repeat (50) tick();
    en = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (fv_a !== 1'b0 || fc_a !== held) begin
        errors++; $display("FAIL abort_hold got v=%0d cnt=%0d exp v=0 cnt=%0d", fv_a, fc_a, held);
      end
    end
    en = 1'b1;
    wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || lat != int'(G) + 1) begin
      errors++; $display("FAIL abort_restart got=%0d exp=%0d", lat, G + 1);
    end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL abort_model got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got;
    wait_valid(int'(G) + 20, lat, got);
    repeat (70) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_mid got=%h exp=0", obs); end
    rst_n = 1'b1;
    wait_valid(int'(G) + 20, lat, got);
    checks++;
    if (!got || lat != int'(G) + 1 || fc_a !== 32'd25 || ir_a !== 1'b1) begin
      errors++; $display("FAIL reset_mid_window got lat=%0d cnt=%0d exp lat=%0d cnt=25", lat, fc_a, G + 1);
    end
  endtask

  task automatic test_random();
    int en_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        per = int'($urandom_range(9, 3));
        hi  = int'($urandom_range(per - 1, 1));
        ph  = ph % per;
      end
      hold_low = (i >= 2000 && i < 2250);
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) en = 1'b1;
      end else if ($urandom_range(299, 0) == 0) begin
        en = 1'b0;
        en_hold = int'($urandom_range(6, 1));
      end
      rst_n = ($urandom_range(1499, 0) != 0);
      tick();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    rst_n = 1'b1; en = 1'b1; hold_low = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_no_clk();
    test_range();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 200_000_000, meaning gate window length in sys_clk cycles (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning width of the edge counter and of freq_cnt.
REQ-003 The block SHALL have parameter EXP_MIN, default 0, meaning the inclusive lower bound for in_range.
REQ-004 The block SHALL have parameter EXP_MAX, default {CNT_W{1'b1}}, meaning the inclusive upper bound for in_range.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous to sys_clk, active-low.
REQ-007 The block SHALL have port en, input, 1 bit: measurement enable, synchronous to sys_clk.
REQ-008 The block SHALL have port clk_test, input, 1 bit: clock under test, asynchronous to sys_clk, frequency below sys_clk/2.
REQ-009 The block SHALL have port freq_cnt, output, CNT_W bits: clk_test rising edges counted in the last completed window.
REQ-010 The block SHALL have port freq_valid, output, 1 bit: one-cycle pulse when freq_cnt updates.
REQ-011 The block SHALL have port in_range, output, 1 bit: EXP_MIN <= freq_cnt <= EXP_MAX.
REQ-012 The block SHALL have port no_clk, output, 1 bit: the last completed window counted zero edges.
REQ-013 The block SHALL have port win_cnt, output, 16 bits: number of completed windows, wrapping.

Function
REQ-014 clk_test SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; edge = s2 & ~s3.
REQ-015 The synchronizer SHALL run regardless of en; only counters are gated.
REQ-016 There SHALL be two states. IDLE: counters held at 0. RUN: window active.
REQ-017 IDLE->RUN SHALL occur on the first cycle en=1; RUN->IDLE SHALL occur on any cycle en=0.
REQ-018 In RUN, gate_cnt SHALL increment every cycle, 0..GATE_CYCLES-1, and edge_cnt SHALL increment on each cycle with edge=1.
REQ-019 edge_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 On the cycle gate_cnt==GATE_CYCLES-1, the next cycle SHALL have: freq_cnt = edge_cnt + edge (saturating); freq_valid=1; win_cnt+1; gate_cnt=0; edge_cnt=0. The next window SHALL start with no dead cycle.
REQ-021 in_range and no_clk SHALL be registered together with freq_cnt, updating on the same cycle as freq_valid.
REQ-022 freq_valid SHALL be high for exactly one cycle per completed window and low otherwise.
REQ-023 en falling mid-window SHALL abort the window: counters cleared, no freq_valid, and freq_cnt, in_range, no_clk and win_cnt retained.
REQ-024 en rising again SHALL start a fresh full window of GATE_CYCLES cycles.
REQ-025 win_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-026 With rst_n=0 at a sys_clk edge, the following SHALL all be 0: s1, s2, s3, state (IDLE), gate_cnt, edge_cnt, freq_cnt, freq_valid, in_range, no_clk, win_cnt.
REQ-027 Reset SHALL take priority over en, and reset mid-window SHALL discard the partial count with no freq_valid.
REQ-028 After rst_n releases with en=1, the first freq_valid SHALL occur GATE_CYCLES+1 cycles after the first RUN cycle.

Verification
REQ-029 GATE_CYCLES=100, clk_test=sys_clk/4, en=1 -> freq_valid every 100 cycles; freq_cnt=25 from the second window on; no_clk=0.
REQ-030 clk_test held low, GATE_CYCLES=100 -> freq_cnt=0, no_clk=1, in_range=1 (EXP_MIN=0), win_cnt increments per window.
REQ-031 CNT_W=4, GATE_CYCLES=100, clk_test=sys_clk/4 -> freq_cnt=15 (saturated), no wrap.
REQ-032 en dropped at gate_cnt=50, then reasserted -> no freq_valid for the aborted window, prior freq_cnt held, next freq_valid 100 cycles after reassert plus 1.
REQ-033 EXP_MIN=24, EXP_MAX=26; clk_test sys_clk/4 then sys_clk/5 -> in_range=1 with freq_cnt=25, then in_range=0 with freq_cnt=20.
REQ-034 rst_n pulsed low at gate_cnt=70 -> all outputs 0 next cycle; first valid window afterwards reports the full 25.
